atm_ledger: RTL and testbench

- Account-ledger responder for the ATM front end.
- Holds a small table of accounts (number, PIN, balance) and services one ATM request at a time over a valid/ready handshake: authenticate, balance query, withdraw, deposit and transfer.
- The ATM session FSM is the initiator; this block is the responder behind it and the sole owner of all balances.

---
 rtl/atm_ledger.sv | 220 ++++++++++++++++++++++
 tb/tb_atm_ledger.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/atm_ledger.sv
// Account-ledger responder: scans a fixed account table and applies
// authenticate, balance, withdraw, deposit and transfer requests to the balances it owns.
module atm_ledger #(
   parameter int unsigned NUM_ACCOUNTS = 4,
   localparam int unsigned ACC_W = 12,
   localparam int unsigned PIN_W = 4,
   localparam int unsigned AMT_W = 11,
   localparam int unsigned OP_W  = 3,
   parameter logic [NUM_ACCOUNTS*ACC_W-1:0] ACC_LIST =
      {12'd1007, 12'd3412, 12'd2816, 12'd2178},
   parameter logic [NUM_ACCOUNTS*PIN_W-1:0] PIN_LIST =
      {4'd1, 4'd9, 4'd6, 4'd4},
   parameter logic [AMT_W-1:0] INIT_BALANCE = 11'd1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             reqValid,
   output logic             reqReady,
   input  logic [OP_W-1:0]  reqOp,
   input  logic [ACC_W-1:0] reqAcc,
   input  logic [PIN_W-1:0] reqPin,
   input  logic [ACC_W-1:0] reqDest,
   input  logic [AMT_W-1:0] reqAmount,
   output logic             rspValid,
   input  logic             rspReady,
   output logic             rspError,
   output logic [AMT_W-1:0] rspBalance
);

   localparam int unsigned IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
   localparam int unsigned SUM_W = AMT_W + 1;
   localparam logic [SUM_W-1:0] BAL_MAX = SUM_W'(2047);

   localparam logic [OP_W-1:0] OP_WITHDRAW = 3'd2;
   localparam logic [OP_W-1:0] OP_DEPOSIT  = 3'd3;
   localparam logic [OP_W-1:0] OP_TRANSFER = 3'd4;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      SEARCH      = 3'd1,
      SEARCH_DEST = 3'd2,
      EXECUTE     = 3'd3,
      RESPOND     = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [OP_W-1:0]  op_q, op_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [PIN_W-1:0] pin_q, pin_d;
   logic [ACC_W-1:0] dest_q, dest_d;
   logic [AMT_W-1:0] amt_q, amt_d;

   logic [IDX_W-1:0] scan_q, scan_d;
   logic             src_found_q, src_found_d;
   logic [IDX_W-1:0] src_idx_q, src_idx_d;
   logic             dst_found_q, dst_found_d;
   logic [IDX_W-1:0] dst_idx_q, dst_idx_d;

   logic [AMT_W-1:0] bal_q [NUM_ACCOUNTS];
   logic [AMT_W-1:0] bal_d [NUM_ACCOUNTS];

   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_error_q, rsp_error_d;
   logic [AMT_W-1:0] rsp_balance_q, rsp_balance_d;

   logic [AMT_W-1:0] src_bal, dst_bal, new_src;
   logic [SUM_W-1:0] src_sum, dst_sum;
   logic             illegal, src_ok, last_entry, exec_err;

   function automatic logic [ACC_W-1:0] acc_at(input logic [IDX_W-1:0] i);
      return ACC_LIST[int'(i)*ACC_W +: ACC_W];
   endfunction

   function automatic logic [PIN_W-1:0] pin_at(input logic [IDX_W-1:0] i);
      return PIN_LIST[int'(i)*PIN_W +: PIN_W];
   endfunction

   assign reqReady   = (state_q == IDLE) && reset_n;
   assign rspValid   = rsp_valid_q;
   assign rspError   = rsp_error_q;
   assign rspBalance = rsp_balance_q;

   // Next-state, scan bookkeeping and balance update
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      acc_d         = acc_q;
      pin_d         = pin_q;
      dest_d        = dest_q;
      amt_d         = amt_q;
      scan_d        = scan_q;
      src_found_d   = src_found_q;
      src_idx_d     = src_idx_q;
      dst_found_d   = dst_found_q;
      dst_idx_d     = dst_idx_q;
      bal_d         = bal_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_error_d   = rsp_error_q;
      rsp_balance_d = rsp_balance_q;

      src_bal    = bal_q[src_idx_q];
      dst_bal    = bal_q[dst_idx_q];
      src_sum    = {1'b0, src_bal} + {1'b0, amt_q};
      dst_sum    = {1'b0, dst_bal} + {1'b0, amt_q};
      illegal    = (op_q > OP_TRANSFER);
      src_ok     = src_found_q && (pin_at(src_idx_q) == pin_q);
      last_entry = (scan_q == IDX_W'(NUM_ACCOUNTS - 1));
      exec_err   = 1'b0;
      new_src    = src_bal;

      unique case (state_q)
         IDLE: begin
            if (reqValid) begin
               op_d        = reqOp;
               acc_d       = reqAcc;
               pin_d       = reqPin;
               dest_d      = reqDest;
               amt_d       = reqAmount;
               scan_d      = '0;
               src_found_d = 1'b0;
               dst_found_d = 1'b0;
               state_d     = SEARCH;
            end
         end
         SEARCH: begin
            if (!src_found_q && (acc_at(scan_q) == acc_q)) begin
               src_found_d = 1'b1;
               src_idx_d   = scan_q;
            end
            if (last_entry) begin
               scan_d  = '0;
               state_d = (op_q == OP_TRANSFER) ? SEARCH_DEST : EXECUTE;
            end else begin
               scan_d = scan_q + IDX_W'(1);
            end
         end
         SEARCH_DEST: begin
            if (!dst_found_q && (acc_at(scan_q) == dest_q)) begin
               dst_found_d = 1'b1;
               dst_idx_d   = scan_q;
            end
            if (last_entry) begin
               scan_d  = '0;
               state_d = EXECUTE;
            end else begin
               scan_d = scan_q + IDX_W'(1);
            end
         end
         EXECUTE: begin
            if (illegal || !src_ok) begin
               exec_err = 1'b1;
            end else if (op_q == OP_WITHDRAW) begin
               if (amt_q > src_bal) exec_err = 1'b1;
               else                 new_src  = src_bal - amt_q;
            end else if (op_q == OP_DEPOSIT) begin
               if (src_sum > BAL_MAX) exec_err = 1'b1;
               else                   new_src  = src_sum[AMT_W-1:0];
            end else if (op_q == OP_TRANSFER) begin
               if (!dst_found_q || (dst_idx_q == src_idx_q) ||
                   (amt_q > src_bal) || (dst_sum > BAL_MAX)) begin
                  exec_err = 1'b1;
               end else begin
                  new_src            = src_bal - amt_q;
                  bal_d[dst_idx_q]   = dst_sum[AMT_W-1:0];
               end
            end
            if (!exec_err) bal_d[src_idx_q] = new_src;
            rsp_valid_d   = 1'b1;
            rsp_error_d   = exec_err;
            rsp_balance_d = (illegal || !src_found_q) ? '0 : new_src;
            state_d       = RESPOND;
         end
         RESPOND: begin
            if (rspReady) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         op_q          <= '0;
         acc_q         <= '0;
         pin_q         <= '0;
         dest_q        <= '0;
         amt_q         <= '0;
         scan_q        <= '0;
         src_found_q   <= 1'b0;
         src_idx_q     <= '0;
         dst_found_q   <= 1'b0;
         dst_idx_q     <= '0;
         for (int i = 0; i < int'(NUM_ACCOUNTS); i++) bal_q[i] <= INIT_BALANCE;
         rsp_valid_q   <= 1'b0;
         rsp_error_q   <= 1'b0;
         rsp_balance_q <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         acc_q         <= acc_d;
         pin_q         <= pin_d;
         dest_q        <= dest_d;
         amt_q         <= amt_d;
         scan_q        <= scan_d;
         src_found_q   <= src_found_d;
         src_idx_q     <= src_idx_d;
         dst_found_q   <= dst_found_d;
         dst_idx_q     <= dst_idx_d;
         bal_q         <= bal_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_error_q   <= rsp_error_d;
         rsp_balance_q <= rsp_balance_d;
      end
   end

endmodule

// File: tb/tb_atm_ledger.sv
// Directed bench for atm_ledger: hand-computed ledger results, response latency,
// backpressure hold and reset abort.
module tb_atm_ledger;

   logic        clk;
   logic        reset_n;
   logic        reqValid;
   logic        reqReady;
   logic [2:0]  reqOp;
   logic [11:0] reqAcc;
   logic [3:0]  reqPin;
   logic [11:0] reqDest;
   logic [10:0] reqAmount;
   logic        rspValid;
   logic        rspReady;
   logic        rspError;
   logic [10:0] rspBalance;

   int n_tests = 0;
   int n_fail  = 0;

   atm_ledger dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .reqValid   (reqValid),
      .reqReady   (reqReady),
      .reqOp      (reqOp),
      .reqAcc     (reqAcc),
      .reqPin     (reqPin),
      .reqDest    (reqDest),
      .reqAmount  (reqAmount),
      .rspValid   (rspValid),
      .rspReady   (rspReady),
      .rspError   (rspError),
      .rspBalance (rspBalance)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present a request, wait for acceptance, then scramble the request bus.
   task automatic issue(input logic [2:0] op, input logic [11:0] acc, input logic [3:0] pin,
                        input logic [11:0] dest, input logic [10:0] amt);
      int waited = 0;
      @(negedge clk);
      while (!reqReady && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!reqReady) begin
         chk("accept_timeout", 32'(0), 32'(1));
         return;
      end
      reqOp = op; reqAcc = acc; reqPin = pin; reqDest = dest; reqAmount = amt;
      reqValid = 1'b1;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      reqOp = 3'd7; reqAcc = 12'hfff; reqPin = 4'hf; reqDest = 12'hfff; reqAmount = 11'h7ff;
   endtask

   // Cycles from the accept edge to the edge after which rspValid is high (-1 on timeout).
   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (rspValid) begin
            lat = i;
            return;
         end
      end
   endtask

   task automatic txn(input string tag, input logic [2:0] op, input logic [11:0] acc,
                      input logic [3:0] pin, input logic [11:0] dest, input logic [10:0] amt,
                      input logic exp_err, input logic [10:0] exp_bal, input int exp_lat);
      int lat;
      issue(op, acc, pin, dest, amt);
      wait_rsp(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_err"}, 32'(rspError), 32'(exp_err));
      chk({tag, "_bal"}, 32'(rspBalance), 32'(exp_bal));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      bit seen;
      reset_n = 1'b0; reqValid = 1'b0; rspReady = 1'b1;
      reqOp = '0; reqAcc = '0; reqPin = '0; reqDest = '0; reqAmount = '0;
      #3;
      chk("rst_reqReady", 32'(reqReady), 32'(0));
      chk("rst_rspValid", 32'(rspValid), 32'(0));
      chk("rst_rspError", 32'(rspError), 32'(0));
      chk("rst_rspBalance", 32'(rspBalance), 32'(0));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("idle_reqReady", 32'(reqReady), 32'(1));

      txn("auth_unknown",  3'd0, 12'd2278, 4'd4, 12'd0,    11'd0,    1'b1, 11'd0,    5);
      txn("auth_ok",       3'd0, 12'd2178, 4'd4, 12'd0,    11'd0,    1'b0, 11'd1000, 5);
      txn("auth_badpin",   3'd0, 12'd2178, 4'd5, 12'd0,    11'd0,    1'b1, 11'd1000, 5);
      txn("wd_100",        3'd2, 12'd2178, 4'd4, 12'd0,    11'd100,  1'b0, 11'd900,  5);
      txn("wd_1500",       3'd2, 12'd2178, 4'd4, 12'd0,    11'd1500, 1'b1, 11'd900,  5);
      txn("op_illegal",    3'd6, 12'd2178, 4'd4, 12'd0,    11'd10,   1'b1, 11'd0,    5);
      txn("xfer_50",       3'd4, 12'd2178, 4'd4, 12'd2816, 11'd50,   1'b0, 11'd850,  9);
      txn("bal_2816",      3'd1, 12'd2816, 4'd6, 12'd0,    11'd0,    1'b0, 11'd1050, 5);
      txn("xfer_self",     3'd4, 12'd2178, 4'd4, 12'd2178, 11'd10,   1'b1, 11'd850,  9);
      txn("xfer_nodest",   3'd4, 12'd2178, 4'd4, 12'(9999), 11'd10,  1'b1, 11'd850,  9);
      txn("dep_500",       3'd3, 12'd2178, 4'd4, 12'd0,    11'd500,  1'b0, 11'd1350, 5);
      txn("dep_1000",      3'd3, 12'd2178, 4'd4, 12'd0,    11'd1000, 1'b1, 11'd1350, 5);
      txn("dep_697",       3'd3, 12'd2178, 4'd4, 12'd0,    11'd697,  1'b0, 11'd2047, 5);
      txn("wd_zero",       3'd2, 12'd2178, 4'd4, 12'd0,    11'd0,    1'b0, 11'd2047, 5);
      txn("xfer_dstovf",   3'd4, 12'd2816, 4'd6, 12'd2178, 11'd1,    1'b1, 11'd1050, 9);

      // Backpressure: response must hold while a new request waits.
      rspReady = 1'b0;
      issue(3'd1, 12'd2816, 4'd6, 12'd0, 11'd0);
      wait_rsp(lat);
      chk("stall_lat", 32'(lat), 32'(5));
      reqOp = 3'd1; reqAcc = 12'd2178; reqPin = 4'd4; reqDest = 12'd0; reqAmount = 11'd0;
      reqValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 32'(rspValid), 32'(1));
         chk("stall_err", 32'(rspError), 32'(0));
         chk("stall_bal", 32'(rspBalance), 32'(1050));
         chk("stall_reqReady", 32'(reqReady), 32'(0));
      end
      @(negedge clk);
      rspReady = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_valid_low", 32'(rspValid), 32'(0));
      chk("hs_reqReady", 32'(reqReady), 32'(1));
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      chk("pend_accepted", 32'(reqReady), 32'(0));
      wait_rsp(lat);
      chk("pend_lat", 32'(lat), 32'(5));
      chk("pend_bal", 32'(rspBalance), 32'(2047));
      @(posedge clk);
      #1;

      // Reset during SEARCH_DEST aborts the transfer.
      issue(3'd4, 12'd2178, 4'd4, 12'd2816, 11'd5);
      repeat (6) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_reqReady", 32'(reqReady), 32'(0));
      chk("abort_valid", 32'(rspValid), 32'(0));
      chk("abort_err", 32'(rspError), 32'(0));
      chk("abort_bal", 32'(rspBalance), 32'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (rspValid) seen = 1'b1;
      end
      chk("abort_no_rsp", 32'(seen), 32'(0));
      txn("post_rst_2178", 3'd1, 12'd2178, 4'd4, 12'd0, 11'd0, 1'b0, 11'd1000, 5);
      txn("post_rst_2816", 3'd1, 12'd2816, 4'd6, 12'd0, 11'd0, 1'b0, 11'd1000, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
